// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: column-serial AES InvMixColumns, one 32-bit column per clock.
// Define FWD_MODE_EN to add a mode input that selects forward MixColumns instead.
module inv_mix_columns_seq #(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef FWD_MODE_EN
    input  logic         mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [127:0] work_q, work_d;
    logic [31:0]  col;
    logic         fwd;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // p[j][k] is byte j times the coefficient at circulant offset k = (j - row) mod 4
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic f);
        logic [7:0]  a, x2, x4, x8;
        logic [7:0]  p [4][4];
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            a  = c[31-8*j -: 8];
            x2 = xt(a);
            x4 = xt(x2);
            x8 = xt(x4);
            p[j][0] = f ? x2      : x8 ^ x4 ^ x2;
            p[j][1] = f ? x2 ^ a  : x8 ^ x2 ^ a;
            p[j][2] = f ? a       : x8 ^ x4 ^ a;
            p[j][3] = f ? a       : x8 ^ a;
        end
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[31-8*i -: 8] = r[31-8*i -: 8] ^ p[j][2'(j - i)];
        return r;
    endfunction

`ifdef FWD_MODE_EN
    logic mode_q, mode_d;
    assign fwd = mode_q;
`else
    assign fwd = 1'b0;
`endif

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_data  = work_q;
    assign col       = work_q[8'd127 - {col_cnt_q, 5'd0} -: 32];

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        work_d    = work_q;
`ifdef FWD_MODE_EN
        mode_d    = mode_q;
`endif
        if (state_q == IDLE && in_valid) begin
            work_d    = in_data;
            col_cnt_d = 2'd0;
            state_d   = CALC;
`ifdef FWD_MODE_EN
            mode_d    = mode;
`endif
        end else if (state_q == CALC) begin
            work_d[8'd127 - {col_cnt_q, 5'd0} -: 32] = mix_col(col, fwd);
            col_cnt_d = col_cnt_q + 2'd1;
            state_d   = col_cnt_q == 2'(NUM_COLS - 1) ? DONE : CALC;
        end else if (state_q == DONE && out_ready) begin
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
            work_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            work_q    <= work_d;
        end
    end

`ifdef FWD_MODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_q <= 1'b0;
        else
            mode_q <= mode_d;
    end
`endif
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: randomized and directed checks of inv_mix_columns_seq
// against a GF(2^8) matrix-multiply reference model.
module tb_inv_mix_columns_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef FWD_MODE_EN
    logic         mode;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc;
    bit hold;
    logic [127:0] exp_q [$];

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef FWD_MODE_EN
        .mode      (mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // Each column is multiplied by the circulant matrix whose first row is coef[0..3].
    function automatic logic [127:0] model(input logic [127:0] s, input bit fwd);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (fwd) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        else     coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gm(coef[(j - row + 4) % 4], s[127-32*c-8*j -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Compare process: invariants every cycle, data whenever out_valid is high.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("ready_vs_busy", 128'(in_ready), 128'(!busy));
            if (out_valid) begin
                chk("valid_implies_busy", 128'(busy), 128'd1);
                if (exp_q.size() == 0)
                    chk("unexpected_out_valid", 128'd1, 128'd0);
                else begin
                    chk("out_data", out_data, exp_q[0]);
                    if (out_ready) exp_q.delete(0);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (!hold) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [127:0] d, input bit m);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
`ifdef FWD_MODE_EN
        mode     = m;
        exp_q.push_back(model(d, m));
`else
        exp_q.push_back(model(d, 1'b0));
`endif
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 128'd0, 128'd1);
            exp_q.delete(exp_q.size() - 1);
            in_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        // garbage on the input side during CALC must be ignored
        in_data = rnd128();
`ifdef FWD_MODE_EN
        mode = ~m;
`endif
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) in_valid = 1'b0;
            chk("latency_out_valid", 128'(out_valid), 128'(k == 4));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [127:0] x;
        int t1;
        hold      = 1'b1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef FWD_MODE_EN
        mode      = 1'b0;
`endif
        #3;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("model_fips", model(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0),
            128'hd4bf5d30e0b452aeb84111f11e2798e5);
        chk("model_col0", model({32'h8e4da1bc, 96'h0}, 1'b0), {32'hdb135345, 96'h0});
        chk("model_ones", model({16{8'h01}}, 1'b0), {16{8'h01}});
        chk("model_c6", model({16{8'hc6}}, 1'b0), {16{8'hc6}});
        chk("model_fwd_fips", model(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1),
            128'h046681e5e0cb199a48f8d37a2806264c);

        // directed vectors, back-to-back with out_ready held high
        out_ready = 1'b1;
        send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0);
        t1 = acc_cyc;
        send('0, 1'b0);
        chk("b2b_spacing", 128'(acc_cyc - t1), 128'd6);
        t1 = acc_cyc;
        send({16{8'h01}}, 1'b0);
        chk("b2b_spacing", 128'(acc_cyc - t1), 128'd6);
        send({16{8'hc6}}, 1'b0);
        send({32'h8e4da1bc, 96'h0}, 1'b0);
        drain();

        // backpressure
        out_ready = 1'b0;
        x = rnd128();
        send(x, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_data", out_data, model(x, 1'b0));
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);

`ifdef FWD_MODE_EN
        out_ready = 1'b1;
        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1);
        x = rnd128();
        chk("model_roundtrip", model(model(x, 1'b1), 1'b0), x);
        send(x, 1'b1);
        send(model(x, 1'b1), 1'b0);
        drain();
`endif

        // randomized traffic with random backpressure
        hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
`ifdef FWD_MODE_EN
            send(rnd128(), 1'($urandom_range(0, 1)));
`else
            send(rnd128(), 1'b0);
`endif
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // reset in the middle of CALC
        hold = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rnd128();
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_out_data", out_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", 128'(in_ready), 128'd1);
        chk("postrst_out_valid", 128'(out_valid), 128'd0);
        chk("postrst_busy", 128'(busy), 128'd0);
        out_ready = 1'b1;
        send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
